instruction_encoder_loader: RTL
===============================

Name: instruction_encoder_loader

Overview:
Inverse of the opcode decode path. Accepts one instruction class, given one-hot in the same order the decoder emits it, plus raw operand fields. Packs them into a 32-bit ISA instruction word and writes the word into instruction memory at consecutive addresses. Used by the bench/boot path to load programs without a precompiled image.

Parameters:
ADDR_W, 12, instruction memory address width
DEPTH, 4096, number of writable words; last address written is DEPTH-1 (DEPTH <= 2^ADDR_W)

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  request carries an instruction this cycle
in_ready  output  1  encoder can accept this cycle
sel  input  11  one-hot class, bits [0..8] = opcodes 0..8, bit 9 = opcode 21 (setx), bit 10 = opcode 22 (bex)
rd  input  5  destination field
rs  input  5  source field
rt  input  5  second source field
shamt  input  5  shift amount
aluop  input  5  ALU op (R-type)
imm  input  17  immediate
target  input  27  jump target / setx value
clear  input  1  synchronous restart: address to 0, leave FULL
imem_wren  output  1  write strobe to instruction memory
imem_addr  output  ADDR_W  write address
imem_data  output  32  encoded instruction word
err  output  1  one-cycle pulse: rejected request
full  output  1  memory filled; no further accepts

Behaviour:
- Reset values: state IDLE, imem_wren=0, imem_addr=0, imem_data=0, err=0, full=0. in_ready=1 (combinational from state).
- Encoding: opcode = [31:27].
  - R-type (bit 0): {00000, rd, rs, rt, shamt, aluop, 2'b00}.
  - JI (j=1, jal=3, setx=21, bex=22): {op, target}.
  - I-type (bne=2, addi=5, blt=6, sw=7, lw=8): {op, rd, rs, imm}.
  - jr (4): {00100, rd, 22'b0}.
  - Unused fields are ignored.
- in_ready = (state==IDLE) & !full.
- Accept occurs when in_valid & in_ready on a rising edge.
- States:
  - IDLE: on accept with sel exactly one-hot, register the encoded word into imem_data and go to WRITE.
  - IDLE, non-one-hot sel (zero bits or >=2 bits): err=1 for the next cycle only. No state change, no write, address unchanged.
  - WRITE: imem_wren=1 for exactly one cycle, with imem_addr/imem_data stable. Next edge:
    - if imem_addr==DEPTH-1: go to FULL, full=1, address held.
    - otherwise: imem_addr+1, return to IDLE.
  - FULL: in_ready=0, in_valid ignored. Leave only via clear or reset.
- Latency: accept at edge N → imem_wren high during cycle N+1 → next accept possible at edge N+2. Max throughput is one word per 2 cycles.
- imem_data holds its last value after the write; it changes only on an accepted valid request.
- clear:
  - In IDLE or FULL: imem_addr=0, full=0, state IDLE on the next edge. clear has priority over a simultaneous accept (the request is dropped, no err).
  - In WRITE: the pending write completes this cycle, then clear takes effect (address 0, IDLE).
- reset asserted mid-WRITE: imem_wren drops immediately (asynchronous). The write is not guaranteed to be performed.
- No address wrap-around; it saturates into FULL.

Test Plan:
- Reset, then accept sel=bit5 (addi), rd=3, rs=1, imm=17'h00005 → cycle+1: imem_wren=1, addr=0, data=32'h28C20005; next accept lands at addr=1.
- R-type add: rd=2, rs=3, rt=4, shamt=0, aluop=0 → data=32'h00864000. jr with rd=31 → data=32'h27C00000. setx target=27'h0000ABC → data=32'hA8000ABC.
- sel=11'b00000000110 and sel=0, each with in_valid → err pulses one cycle, no imem_wren, addr unchanged, in_ready stays 1.
- DEPTH=4: four back-to-back valid requests → writes at 0..3, then full=1 and in_ready=0. A fifth request produces no write. clear → addr=0, full=0, next write at 0.
- in_valid held high continuously → writes occur every 2nd cycle. in_ready low during each WRITE cycle.
- Assert reset during the WRITE cycle → imem_wren=0 and addr=0 asynchronously. clear asserted during WRITE → that write completes, then the next write goes to addr 0.

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// Packs a one-hot instruction class plus operand fields into a 32-bit word and writes it to consecutive imem addresses.
// Accept at edge N, write strobe in cycle N+1, next accept at N+2; in_ready low while writing or once memory is full.
module instruction_encoder_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [4:0]        aluop,
    input  logic [16:0]       imm,
    input  logic [26:0]       target,
    input  logic              clear,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              err,
    output logic              full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;
    logic                sel_onehot;
    logic [31:0]         enc_word;

    assign sel_onehot = (sel != 11'd0) && ((sel & (sel - 11'd1)) == 11'd0);

    always_comb begin
        enc_word = 32'd0;
        case (sel)
            11'b000_0000_0001: enc_word = {5'd0, rd, rs, rt, shamt, aluop, 2'b00};
            11'b000_0000_0010: enc_word = {5'd1, target};
            11'b000_0000_0100: enc_word = {5'd2, rd, rs, imm};
            11'b000_0000_1000: enc_word = {5'd3, target};
            11'b000_0001_0000: enc_word = {5'd4, rd, 22'd0};
            11'b000_0010_0000: enc_word = {5'd5, rd, rs, imm};
            11'b000_0100_0000: enc_word = {5'd6, rd, rs, imm};
            11'b000_1000_0000: enc_word = {5'd7, rd, rs, imm};
            11'b001_0000_0000: enc_word = {5'd8, rd, rs, imm};
            11'b010_0000_0000: enc_word = {5'd21, target};
            11'b100_0000_0000: enc_word = {5'd22, target};
            default:           enc_word = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // clear wins over a simultaneous request; the request is dropped silently
                if (clear) begin
                    addr_d = '0;
                end else if (in_valid) begin
                    if (sel_onehot) begin
                        data_d  = enc_word;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (clear) begin
                    addr_d  = '0;
                    state_d = IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = FULL;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = IDLE;
                end
            end
            FULL: begin
                if (clear) begin
                    addr_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Strobe decoded from state so an asynchronous reset kills it immediately
    assign imem_wren = (state_q == WRITE);
    assign full      = (state_q == FULL);
    assign in_ready  = (state_q == IDLE);
    assign imem_addr = addr_q;
    assign imem_data = data_q;
    assign err       = err_q;

endmodule
